// File: rtl/async_fifo_wptr_ctrl.sv
// Write-side pointer and flag controller for the dual-clock FIFO.
// Owns the binary and Gray write pointers, RAM write port, and the full, almost-full, level and overflow flags.
module async_fifo_wptr_ctrl #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              winc,
  input  logic [ADDR_W:0]   wq2_rptr,
  input  logic [ADDR_W:0]   afull_thr,
  input  logic              wovf_clr,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W-1:0] waddr,
  output logic              wclken,
  output logic              wfull,
  output logic              wafull,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf
);

  localparam int unsigned PW = ADDR_W + 1;
  // Full when the write pointer equals the read pointer with its top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_n;
  logic [PW-1:0] wgray_n;
  logic [PW-1:0] rbin;
  logic [PW-1:0] lvl_n;
  logic          push;
  logic          wafull_q;

  // Next pointer values for this cycle's write.
  always_comb begin
    push    = winc & ~wfull;
    wbin_n  = wbin + PW'(push);
    wgray_n = wbin_n ^ (wbin_n >> 1);
  end

  // Gray-to-binary of the synchronised read pointer: each bit is the XOR of itself and all bits above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  assign lvl_n = wbin_n - rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin     <= '0;
      wptr     <= '0;
      wfull    <= 1'b0;
      wlevel   <= '0;
      wafull_q <= 1'b0;
      wovf     <= 1'b0;
    end else begin
      wbin     <= wbin_n;
      wptr     <= wgray_n;
      wfull    <= (wgray_n == (wq2_rptr ^ FULL_MASK));
      wlevel   <= lvl_n;
      wafull_q <= (lvl_n >= afull_thr);
      if (winc & wfull) begin
        wovf <= 1'b1;
      end else if (wovf_clr) begin
        wovf <= 1'b0;
      end
    end
  end

  assign waddr  = wbin[ADDR_W-1:0];
  assign wclken = push;
  // A zero threshold is always met, including through reset, so it bypasses the register.
  assign wafull = wafull_q | (afull_thr == '0);

endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Directed bench for async_fifo_wptr_ctrl: table-driven fill/overflow/drain vectors,
// then reset, wrap and ADDR_W = 1 / 5 sequences with a Gray one-bit-step check on every pointer.
module tb_async_fifo_wptr_ctrl;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic       wovf_clr;
  logic [3:0] wq2_rptr;
  logic [3:0] afull_thr;
  logic [3:0] wptr;
  logic [2:0] waddr;
  logic       wclken, wfull, wafull, wovf;
  logic [3:0] wlevel;

  logic       winc1, winc5;
  logic [1:0] p1_wptr, p1_wlevel;
  logic [0:0] p1_waddr;
  logic       p1_wclken, p1_wfull, p1_wafull, p1_wovf;
  logic [5:0] p5_wptr, p5_wlevel;
  logic [4:0] p5_waddr;
  logic       p5_wclken, p5_wfull, p5_wafull, p5_wovf;

  int checks = 0;
  int errors = 0;

  always #5 wclk = ~wclk;

  async_fifo_wptr_ctrl #(.ADDR_W(3)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .afull_thr(afull_thr), .wovf_clr(wovf_clr), .wptr(wptr), .waddr(waddr),
    .wclken(wclken), .wfull(wfull), .wafull(wafull), .wlevel(wlevel), .wovf(wovf)
  );

  async_fifo_wptr_ctrl #(.ADDR_W(1)) dut1 (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc1), .wq2_rptr(2'b00),
    .afull_thr(2'b00), .wovf_clr(1'b0), .wptr(p1_wptr), .waddr(p1_waddr),
    .wclken(p1_wclken), .wfull(p1_wfull), .wafull(p1_wafull), .wlevel(p1_wlevel), .wovf(p1_wovf)
  );

  async_fifo_wptr_ctrl #(.ADDR_W(5)) dut5 (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc5), .wq2_rptr(6'b000000),
    .afull_thr(6'd33), .wovf_clr(1'b0), .wptr(p5_wptr), .waddr(p5_waddr),
    .wclken(p5_wclken), .wfull(p5_wfull), .wafull(p5_wafull), .wlevel(p5_wlevel), .wovf(p5_wovf)
  );

  typedef struct {
    logic       winc;
    logic       clr;
    logic [3:0] rptr;
    logic       e_clken;
    logic [3:0] e_wptr;
    logic [2:0] e_waddr;
    logic       e_full;
    logic       e_afull;
    logic [3:0] e_lvl;
    logic       e_ovf;
  } vec_t;

  vec_t vt[15];

  logic [3:0] prev3;
  logic [1:0] prev1;
  logic [5:0] prev5;
  bit         gvalid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic wi, input logic cl, input logic [3:0] rp,
                              input logic ck, input logic [3:0] wp, input logic [2:0] wa,
                              input logic fu, input logic af, input logic [3:0] lv,
                              input logic ov);
    vec_t v;
    v.winc = wi; v.clr = cl; v.rptr = rp; v.e_clken = ck; v.e_wptr = wp;
    v.e_waddr = wa; v.e_full = fu; v.e_afull = af; v.e_lvl = lv; v.e_ovf = ov;
    return v;
  endfunction

  // Advance one edge, then check every pointer moved by at most one Gray bit.
  task automatic tick();
    @(posedge wclk);
    #1;
    if (wrst_n) begin
      if (gvalid) begin
        chk("gray_step3", 32'($countones(prev3 ^ wptr) <= 1), 1);
        chk("gray_step1", 32'($countones(prev1 ^ p1_wptr) <= 1), 1);
        chk("gray_step5", 32'($countones(prev5 ^ p5_wptr) <= 1), 1);
      end
      prev3  = wptr;
      prev1  = p1_wptr;
      prev5  = p5_wptr;
      gvalid = 1'b1;
    end else begin
      gvalid = 1'b0;
    end
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_wptr"},   32'(wptr),   0);
    chk({tag, "_waddr"},  32'(waddr),  0);
    chk({tag, "_wfull"},  32'(wfull),  0);
    chk({tag, "_wafull"}, 32'(wafull), 0);
    chk({tag, "_wlevel"}, 32'(wlevel), 0);
    chk({tag, "_wovf"},   32'(wovf),   0);
    chk({tag, "_p1_wafull_thr0"}, 32'(p1_wafull), 1);
    chk({tag, "_p5_wafull_thr33"}, 32'(p5_wafull), 0);
  endtask

  logic [3:0] exp_bin;
  logic [3:0] last_wptr;
  bit         saw_wrap;

  initial begin
    // winc, clr, rptr | clken(pre-edge), wptr, waddr, full, afull, level, ovf
    vt[0]  = mk(1, 0, 4'b0000, 1, 4'b0001, 3'd1, 0, 0, 4'd1, 0);
    vt[1]  = mk(1, 0, 4'b0000, 1, 4'b0011, 3'd2, 0, 0, 4'd2, 0);
    vt[2]  = mk(1, 0, 4'b0000, 1, 4'b0010, 3'd3, 0, 0, 4'd3, 0);
    vt[3]  = mk(1, 0, 4'b0000, 1, 4'b0110, 3'd4, 0, 0, 4'd4, 0);
    vt[4]  = mk(1, 0, 4'b0000, 1, 4'b0111, 3'd5, 0, 0, 4'd5, 0);
    vt[5]  = mk(1, 0, 4'b0000, 1, 4'b0101, 3'd6, 0, 1, 4'd6, 0);
    vt[6]  = mk(1, 0, 4'b0000, 1, 4'b0100, 3'd7, 0, 1, 4'd7, 0);
    vt[7]  = mk(1, 0, 4'b0000, 1, 4'b1100, 3'd0, 1, 1, 4'd8, 0);
    vt[8]  = mk(1, 0, 4'b0000, 0, 4'b1100, 3'd0, 1, 1, 4'd8, 1);
    vt[9]  = mk(1, 0, 4'b0000, 0, 4'b1100, 3'd0, 1, 1, 4'd8, 1);
    vt[10] = mk(1, 0, 4'b0000, 0, 4'b1100, 3'd0, 1, 1, 4'd8, 1);
    vt[11] = mk(1, 1, 4'b0000, 0, 4'b1100, 3'd0, 1, 1, 4'd8, 1);
    vt[12] = mk(0, 1, 4'b0000, 0, 4'b1100, 3'd0, 1, 1, 4'd8, 0);
    vt[13] = mk(0, 0, 4'b0001, 0, 4'b1100, 3'd0, 0, 1, 4'd7, 0);
    vt[14] = mk(1, 0, 4'b0001, 1, 4'b1101, 3'd1, 1, 1, 4'd8, 0);

    wrst_n    = 1'b0;
    winc      = 1'b0;
    wovf_clr  = 1'b0;
    wq2_rptr  = 4'b0000;
    afull_thr = 4'd6;
    winc1     = 1'b0;
    winc5     = 1'b0;
    #12;
    chk_all_reset("init_reset");
    wrst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      winc     = vt[i].winc;
      wovf_clr = vt[i].clr;
      wq2_rptr = vt[i].rptr;
      #1;
      chk($sformatf("v%0d_wclken", i), 32'(wclken), 32'(vt[i].e_clken));
      tick();
      chk($sformatf("v%0d_wptr", i),   32'(wptr),   32'(vt[i].e_wptr));
      chk($sformatf("v%0d_waddr", i),  32'(waddr),  32'(vt[i].e_waddr));
      chk($sformatf("v%0d_wfull", i),  32'(wfull),  32'(vt[i].e_full));
      chk($sformatf("v%0d_wafull", i), 32'(wafull), 32'(vt[i].e_afull));
      chk($sformatf("v%0d_wlevel", i), 32'(wlevel), 32'(vt[i].e_lvl));
      chk($sformatf("v%0d_wovf", i),   32'(wovf),   32'(vt[i].e_ovf));
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    winc     = 1'b1;
    wovf_clr = 1'b0;
    tick();
    chk("pre_reset_wovf", 32'(wovf), 1);
    winc = 1'b0;
    #2;
    wrst_n = 1'b0;
    #1;
    chk_all_reset("async_reset");
    tick();
    tick();
    chk_all_reset("held_reset");
    #2;
    wrst_n   = 1'b1;
    wq2_rptr = 4'b0000;
    tick();

    // Wrap: preload four entries, then stream with the read pointer four behind.
    exp_bin  = 4'd0;
    saw_wrap = 1'b0;
    for (int n = 0; n < 4; n++) begin
      winc = 1'b1;
      tick();
      exp_bin++;
      chk($sformatf("preload%0d_wlevel", n), 32'(wlevel), 32'(n + 1));
    end
    for (int n = 0; n < 20; n++) begin
      last_wptr = wptr;
      wq2_rptr  = g4(exp_bin - 4'd3);
      winc      = 1'b1;
      tick();
      exp_bin++;
      if (last_wptr == 4'b1000 && wptr == 4'b0000) saw_wrap = 1'b1;
      chk($sformatf("wrap%0d_wptr", n),   32'(wptr),   32'(g4(exp_bin)));
      chk($sformatf("wrap%0d_wlevel", n), 32'(wlevel), 4);
      chk($sformatf("wrap%0d_wfull", n),  32'(wfull),  0);
      chk($sformatf("wrap%0d_wafull", n), 32'(wafull), 0);
    end
    chk("wrap_seen_1000_to_0000", 32'(saw_wrap), 1);
    winc = 1'b0;

    // Parameter sweep: the ADDR_W = 1 and ADDR_W = 5 instances have been idle since reset.
    winc1 = 1'b1;
    winc5 = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      tick();
      chk($sformatf("aw1_n%0d_wfull", n),  32'(p1_wfull),  32'(n >= 2));
      chk($sformatf("aw1_n%0d_wlevel", n), 32'(p1_wlevel), 32'((n >= 2) ? 2 : n));
      chk($sformatf("aw1_n%0d_wovf", n),   32'(p1_wovf),   32'(n >= 3));
      chk($sformatf("aw1_n%0d_wafull", n), 32'(p1_wafull), 1);
      chk($sformatf("aw5_n%0d_wfull", n),  32'(p5_wfull),  32'(n >= 32));
      chk($sformatf("aw5_n%0d_wlevel", n), 32'(p5_wlevel), 32'((n >= 32) ? 32 : n));
      chk($sformatf("aw5_n%0d_wovf", n),   32'(p5_wovf),   32'(n >= 33));
      chk($sformatf("aw5_n%0d_wafull", n), 32'(p5_wafull), 0);
      if (n == 32) chk("aw5_full_wptr", 32'(p5_wptr), 32'(6'b110000));
    end
    winc1 = 1'b0;
    winc5 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
